vram_port_arbiter: RTL
======================

# vram_port_arbiter

Arbitrates the single-port 12-bit framebuffer RAM (one clock, 1-cycle synchronous read, write-first-unspecified) between two requesters: the VGA pixel fetch (high priority, one read per cycle) and a host port (draw engine / UART loader, reads and writes via valid/ready). It drives the RAM's `we`/`addr`/`din` and consumes its `dout`. It tags each issued access and routes the read data back to the correct requester. It range-checks addresses. An optional starvation guard bounds host wait time during active video.

## Interface
- `DWORD`, 16384: RAM depth in words.
- `DWIDTH`, 12: word width (RGB444).
- `AWIDTH`, `$clog2(DWORD+1)`: address width, 15 at default.
- `MAX_WAIT`, 8: host wait-cycle limit for the starvation guard, valid range 1..255.

Ports:
- `clk`: in, 1. Single clock.
- `rst_n`: in, 1. Reset, asynchronous assert, active-low.
- `px_req`: in, 1. Pixel read request this cycle.
- `px_addr`: in, AWIDTH. Pixel address.
- `px_rvalid`: out, 1. Pixel response valid, one cycle after request.
- `px_rdata`: out, DWIDTH. Pixel data.
- `px_miss`: out, 1. Response not serviced; `px_rdata` is the held last pixel.
- `host_valid`: in, 1. Host request valid; request held stable until accepted.
- `host_ready`: out, 1. Host request accepted this cycle when high together with `host_valid`.
- `host_we`: in, 1. 1 = write, 0 = read.
- `host_addr`: in, AWIDTH. Host address.
- `host_wdata`: in, DWIDTH. Host write data.
- `host_rvalid`: out, 1. Host read response valid.
- `host_rdata`: out, DWIDTH. Host read data.
- `host_err`: out, 1. Qualifies `host_rvalid`: out-of-range address.
- `ram_we`: out, 1. To RAM.
- `ram_addr`: out, AWIDTH. To RAM.
- `ram_din`: out, DWIDTH. To RAM.
- `ram_dout`: in, DWIDTH. From RAM, valid one cycle after `ram_addr`.

## Operation
- Grant is combinational each cycle.
  - `host_ready = !px_req || force`.
  - The pixel port is granted when `px_req && !force`.
  - `force` is the starvation guard output, defined under Configuration. It is 0 when the guard is compiled out.
- RAM drive:
  - The granted requester's address goes onto `ram_addr`.
  - `ram_we = host grant && host_valid && host_we && in-range`.
  - `ram_din = host_wdata`.
  - With no grant, `ram_addr` holds 0 and `ram_we` is 0.
- Response tag flops, registered on each edge:
  - `px_tag` = pixel granted.
  - `pxm_tag` = `px_req && force`.
  - `hr_tag` = host read accepted.
  - `oor_tag` = the accepted address was `>= DWORD`.
- Pixel response:
  - `px_rvalid = px_tag | pxm_tag`.
  - `px_rdata` = `ram_dout` when `px_tag` and in-range.
  - `px_rdata` = 0 when `px_tag` and out-of-range (blank border).
  - `px_rdata` = `hold` when `pxm_tag`.
  - `hold` updates to `ram_dout` on every in-range `px_tag` cycle.
  - `px_miss = pxm_tag`.
- Host response:
  - `host_rvalid = hr_tag`.
  - `host_rdata` = `ram_dout`, or 0 if `oor_tag`.
  - `host_err = hr_tag && oor_tag`.
- Out-of-range host writes:
  - Accepted with `host_ready` as normal.
  - Dropped: `ram_we` stays 0.
  - No response is generated.
- Host writes generate no response. Host reads generate exactly one response.

## Timing
- Pixel read latency is 1 cycle: request at edge N, `px_rvalid` and `px_rdata` valid after edge N+1.
- Host read latency is 1 cycle from acceptance.
- A host write is committed at the acceptance edge.
- Back-to-back accesses are allowed every cycle on either port. Throughput is 1 access per cycle total.
- Reset (`rst_n` low, asynchronous) clears the following to 0:
  - all tags, `hold`, and the wait counter;
  - `px_rvalid`, `px_miss`, `host_rvalid`, `host_err`, `px_rdata`, `host_rdata`.
- Combinational outputs during reset:
  - `host_ready` follows its equation.
  - `ram_we` is forced to 0.
- A response in flight when reset asserts is discarded. No response appears after release.
- When the pixel and host ports request the same address in the same cycle, only the grantee is serviced. No bypass.

## Configuration
- `VRAM_ARB_STARVE_GUARD_EN` defined:
  - An 8-bit `wait_cnt` increments, saturating, on each cycle with `host_valid && !host_ready`.
  - It clears on host acceptance or when `host_valid` is low.
  - `force = host_valid && (wait_cnt == MAX_WAIT)`.
  - The forced cycle pre-empts the pixel request, producing one `px_miss` response.
- `VRAM_ARB_STARVE_GUARD_EN` undefined:
  - `force` is tied to 0: strict pixel priority.
  - The host may wait indefinitely while `px_req` is held.
  - `px_miss` is constant 0 and `hold` is not built.

## Test plan
- Host write 0x0ABC to addr 5 with `px_req` low, then host read addr 5 → `host_ready` is 1 on both requests; `host_rvalid` is high one cycle after the read with `host_rdata` = 0x0ABC and `host_err` = 0.
- Pixel reads of addrs 0..3 on consecutive cycles, RAM preloaded 0x100..0x103 → `px_rvalid` is high for 4 consecutive cycles with data 0x100..0x103, each one cycle after its request.
- Guard enabled, `MAX_WAIT` = 8, `px_req` held high, host read of addr 2 (RAM 0x222) → host accepted after exactly 8 stalled cycles; in that cycle the pixel response has `px_miss` = 1 with `px_rdata` = the previous pixel; next cycle `host_rdata` = 0x222.
- Guard disabled, same stimulus for 100 cycles → `host_ready` stays 0 and `px_miss` stays 0.
- Host write to addr 16384 with data 0xFFF, then read of addr 16384 → `ram_we` stays 0 and RAM is unchanged; the read gives `host_rvalid` = 1, `host_err` = 1, `host_rdata` = 0. A pixel read of addr 16400 gives `px_rdata` = 0.
- Assert `rst_n` low mid-cycle with a host read in flight → all registered outputs drop to 0 immediately, and no `host_rvalid` appears after release.

Source files
------------

// File: rtl/vram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : vram_port_arbiter
// Brief   : Single-port framebuffer RAM arbiter between the VGA pixel fetch
//           (high priority, one read per cycle) and a valid/ready host port.
//           Tags every issued access, routes the 1-cycle read data back to
//           its requester and blanks / flags out-of-range addresses.
//           Optional feature macro: VRAM_ARB_STARVE_GUARD_EN (bounded host
//           wait during active video; undefined = strict pixel priority).
// Revision: 1.0 - initial release
// ============================================================================
module vram_port_arbiter #(
    parameter int DWORD    = 16384,
    parameter int DWIDTH   = 12,
    parameter int AWIDTH   = $clog2(DWORD + 1),
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    // pixel fetch port
    input  logic              px_req,
    input  logic [AWIDTH-1:0] px_addr,
    output logic              px_rvalid,
    output logic [DWIDTH-1:0] px_rdata,
    output logic              px_miss,
    // host port
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [AWIDTH-1:0] host_addr,
    input  logic [DWIDTH-1:0] host_wdata,
    output logic              host_rvalid,
    output logic [DWIDTH-1:0] host_rdata,
    output logic              host_err,
    // RAM side
    output logic              ram_we,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_din,
    input  logic [DWIDTH-1:0] ram_dout
);

    // First illegal address; AWIDTH is sized so that DWORD itself fits.
    localparam logic [AWIDTH-1:0] c_DEPTH = AWIDTH'(DWORD);

    logic w_force;       // starvation guard pre-empts the pixel port
    logic w_px_grant;    // pixel read issued this cycle
    logic w_host_acc;    // host request accepted this cycle
    logic w_px_oor;
    logic w_host_oor;
    logic w_acc_oor;     // range status of whichever access is issued
    logic w_pxm_tag;     // pixel response that was pre-empted

    logic r_px_tag;
    logic r_hr_tag;
    logic r_oor_tag;

    // ------------------------------------------------------------------------
    // Grant: the pixel port wins unless the guard forces a host slot.
    // ------------------------------------------------------------------------
    assign w_px_oor   = (px_addr >= c_DEPTH);
    assign w_host_oor = (host_addr >= c_DEPTH);

    assign host_ready = !px_req || w_force;
    assign w_px_grant = px_req && !w_force;
    assign w_host_acc = host_ready && host_valid;

    // Pixel and host grants are mutually exclusive, so one range flag suffices.
    assign w_acc_oor  = w_px_grant ? w_px_oor : w_host_oor;

    // Drive the RAM address from the granted requester, idle address 0.
    always_comb begin
        ram_addr = '0;
        if (w_px_grant) begin
            ram_addr = px_addr;
        end else if (w_host_acc) begin
            ram_addr = host_addr;
        end
    end

    // Out-of-range writes are accepted but never reach the RAM; no writes
    // are issued while reset is held.
    assign ram_we  = rst_n && w_host_acc && host_we && !w_host_oor;
    assign ram_din = host_wdata;

    // Response tags: remember who owns the RAM read data of the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_px_tag  <= 1'b0;
            r_hr_tag  <= 1'b0;
            r_oor_tag <= 1'b0;
        end else begin
            r_px_tag  <= w_px_grant;
            r_hr_tag  <= w_host_acc && !host_we;
            r_oor_tag <= w_acc_oor;
        end
    end

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam logic [7:0] c_MAX_WAIT = 8'(MAX_WAIT);

    logic [7:0]        r_wait_cnt;
    logic              r_pxm_tag;
    logic [DWIDTH-1:0] r_hold;

    // Count consecutive stalled host cycles, saturating at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 8'd0;
        end else if (!host_valid || host_ready) begin
            r_wait_cnt <= 8'd0;
        end else if (r_wait_cnt != 8'hFF) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    assign w_force = host_valid && (r_wait_cnt == c_MAX_WAIT);

    // Tag the pre-empted pixel request so it is answered with held data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pxm_tag <= 1'b0;
        end else begin
            r_pxm_tag <= px_req && w_force;
        end
    end

    // Keep the most recent in-range pixel to replay on a missed slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (r_px_tag && !r_oor_tag) begin
            r_hold <= ram_dout;
        end
    end

    assign w_pxm_tag = r_pxm_tag;
`else
    // Strict pixel priority: the wait limit has no effect in this build.
    logic [7:0] w_unused_max_wait;
    assign w_unused_max_wait = 8'(MAX_WAIT);

    assign w_force   = 1'b0;
    assign w_pxm_tag = 1'b0;
`endif

    // Pixel response mux: RAM data, blank border, or replayed pixel.
    always_comb begin
        px_rdata = '0;
        if (r_px_tag) begin
            px_rdata = r_oor_tag ? '0 : ram_dout;
        end
`ifdef VRAM_ARB_STARVE_GUARD_EN
        else if (r_pxm_tag) begin
            px_rdata = r_hold;
        end
`endif
    end

    assign px_rvalid   = r_px_tag || w_pxm_tag;
    assign px_miss     = w_pxm_tag;

    assign host_rvalid = r_hr_tag;
    assign host_err    = r_hr_tag && r_oor_tag;
    assign host_rdata  = (r_hr_tag && !r_oor_tag) ? ram_dout : '0;

endmodule
`default_nettype wire
